// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the 9-bit core.
// Holds the instruction register and sequences FETCH/DECODE/EXEC/MEM/WB.
// It drives ALUOp/FunctBit into the ALU decoder and strobes the PC,
// register-file and data-memory enables.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               leave IDLE (sampled in IDLE only)
//   imem_req/ack/rdata  instruction fetch handshake and data
//   dmem_req/we/ack     data access handshake (we=1 store)
//   alu_zero            ALU zero flag, used by branches in EXEC
//   ALUOp, FunctBit     instruction class/funct to the ALU decoder
//   ir                  instruction register
//   pc_inc, pc_load     PC increment / PC load strobes
//   reg_we              register-file write strobe
//   halted              sticky halt indication
//   state               current FSM state (debug)
//   cycle_count         saturating count of cycles outside IDLE/HALT
//   instr_count         saturating count of retired instructions
module multicycle_ctrl #(
  parameter int IW    = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [IW-1:0]    imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             alu_zero,
  output logic [1:0]       ALUOp,
  output logic [3:0]       FunctBit,
  output logic [IW-1:0]    ir,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             reg_we,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  logic [1:0] cls;
  logic [3:0] funct;
  logic       is_halt, is_store, retire, in_decode_to_wb;

  assign cls      = ir_q[IW-1 -: 2];
  assign funct    = ir_q[IW-3 -: 4];
  assign is_halt  = (cls == 2'b11) && (funct[3:2] == 2'b11);
  assign is_store = (cls == 2'b11) && (funct[3:2] == 2'b01);

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    reg_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          2'b00, 2'b01: state_d = S_WB;
          2'b10: begin
            // funct[3]=1 is unconditional; otherwise taken on zero
            pc_load = funct[3] | alu_zero;
            state_d = S_FETCH;
          end
          default: begin
            if (!funct[3]) begin
              state_d = S_MEM;
            end else begin
              // funct[3:2]=11 (halt) never reaches EXEC
              pc_load = ~funct[2];
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) state_d = is_store ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign retire = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))
                  && (state_d == S_FETCH);

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if ((state_q != S_IDLE) && (state_q != S_HALT) && (cycle_cnt_q != '1))
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    if (retire && (instr_cnt_q != '1))
      instr_cnt_d = instr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign in_decode_to_wb = (state_q >= S_DECODE) && (state_q <= S_WB);
  assign ALUOp       = in_decode_to_wb ? cls   : 2'b00;
  assign FunctBit    = in_decode_to_wb ? funct : 4'b0000;
  assign ir          = ir_q;
  assign halted      = (state_q == S_HALT);
  assign state       = state_q;
  assign cycle_count = cycle_cnt_q;
  assign instr_count = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          rst_n, start, imem_ack, dmem_ack, alu_zero;
  logic [IW-1:0] imem_rdata;

  logic          imem_req, dmem_req, dmem_we, pc_inc, pc_load, reg_we, halted;
  logic [1:0]    ALUOp;
  logic [3:0]    FunctBit;
  logic [IW-1:0] ir;
  logic [2:0]    state;
  logic [15:0]   cycle_count, instr_count;

  logic          s_imem_req, s_dmem_req, s_dmem_we, s_pc_inc, s_pc_load, s_reg_we, s_halted;
  logic [1:0]    s_ALUOp;
  logic [3:0]    s_FunctBit;
  logic [IW-1:0] s_ir;
  logic [2:0]    s_state;
  logic [3:0]    s_cycle_count, s_instr_count;

  always #5 clk = ~clk;

  multicycle_ctrl #(.IW(IW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .ALUOp(ALUOp), .FunctBit(FunctBit), .ir(ir),
    .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we), .halted(halted),
    .state(state), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  multicycle_ctrl #(.IW(IW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(s_imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .ALUOp(s_ALUOp), .FunctBit(s_FunctBit), .ir(s_ir),
    .pc_inc(s_pc_inc), .pc_load(s_pc_load), .reg_we(s_reg_we), .halted(s_halted),
    .state(s_state), .cycle_count(s_cycle_count), .instr_count(s_instr_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [IW-1:0] ir;
    int            cycles;
    logic [31:0]   trace;
    int            n_inc, n_load, n_rwe, n_dreq, n_dwe, retire;
    logic [1:0]    aluop;
    logic [3:0]    funct;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] push_st(input logic [31:0] tr, input int s);
    return (tr << 3) | 32'(s);
  endfunction

  // Reference behaviour of one instruction, starting from FETCH
  task automatic push_expect(input logic [IW-1:0] instr, input logic zero, input int dly);
    exp_t e;
    logic [1:0] c;
    logic [3:0] f;
    c = instr[8:7];
    f = instr[6:3];
    e.ir = instr; e.n_inc = 1; e.n_load = 0; e.n_rwe = 0; e.n_dreq = 0; e.n_dwe = 0;
    e.retire = 1; e.aluop = c; e.funct = f;
    e.trace = push_st(push_st(push_st(0, 1), 2), 3);
    e.cycles = 3;
    if (c == 2'b00 || c == 2'b01) begin
      e.trace = push_st(e.trace, 5); e.cycles = 4; e.n_rwe = 1;
    end else if (c == 2'b10) begin
      e.n_load = (f[3] || zero) ? 1 : 0;
    end else if (f[3:2] == 2'b11) begin
      e.trace = push_st(push_st(0, 1), 2); e.cycles = 2; e.retire = 0;
      e.aluop = 2'b00; e.funct = 4'b0000;
    end else if (f[3:2] == 2'b10) begin
      e.n_load = 1;
    end else begin
      for (int i = 0; i <= dly; i++) e.trace = push_st(e.trace, 4);
      e.cycles = 4 + dly; e.n_dreq = dly + 1;
      if (f[3:2] == 2'b01) e.n_dwe = dly + 1;
      else begin e.trace = push_st(e.trace, 5); e.cycles++; e.n_rwe = 1; end
    end
    sb.push_back(e);
  endtask

  // Entered just after the edge into FETCH; returns just after the edge
  // back into FETCH (or into HALT).
  task automatic run_instr(input logic [IW-1:0] instr, input logic zero, input int dly);
    exp_t e;
    int cyc = 0, dwait = 0, n_inc = 0, n_load = 0, n_rwe = 0, n_dreq = 0, n_dwe = 0;
    int both = 0, fetch_alu = 0;
    logic [31:0] tr = 0;
    logic [1:0]  op = 2'b00;
    logic [3:0]  fn = 4'b0000;
    int cc0, ic0;
    cc0 = int'(cycle_count);
    ic0 = int'(instr_count);
    push_expect(instr, zero, dly);
    while (1) begin
      @(negedge clk);
      imem_ack   = imem_req;
      imem_rdata = instr;
      alu_zero   = zero;
      dmem_ack   = dmem_req && (dwait == dly);
      #1;
      tr = push_st(tr, int'(state));
      if (pc_inc) n_inc++;
      if (pc_load) n_load++;
      if (pc_inc && pc_load) both++;
      if (reg_we) n_rwe++;
      if (dmem_req) begin n_dreq++; dwait++; end
      if (dmem_req && dmem_we) n_dwe++;
      if (state == 3'd1 && (ALUOp != 2'b00 || FunctBit != 4'b0000)) fetch_alu++;
      if (state == 3'd3) begin op = ALUOp; fn = FunctBit; end
      cyc++;
      @(posedge clk); #1;
      if (state == 3'd1 || state == 3'd6 || cyc >= 40) break;
    end
    check("cycle_bound", (cyc < 40) ? 1 : 0, 1);
    e = sb.pop_front();
    check("ir", ir, e.ir);
    check("cycles", cyc, e.cycles);
    check("state_trace", tr, e.trace);
    check("pc_inc_pulses", n_inc, e.n_inc);
    check("pc_load_pulses", n_load, e.n_load);
    check("pc_inc_and_load", both, 0);
    check("reg_we_pulses", n_rwe, e.n_rwe);
    check("dmem_req_cycles", n_dreq, e.n_dreq);
    check("dmem_we_cycles", n_dwe, e.n_dwe);
    check("alu_in_fetch", fetch_alu, 0);
    check("ALUOp_exec", op, e.aluop);
    check("FunctBit_exec", fn, e.funct);
    check("cycle_count_delta", int'(cycle_count) - cc0, e.cycles);
    check("instr_count_delta", int'(instr_count) - ic0, e.retire);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_to_fetch", state, 3'd1);
  endtask

  int cc_hold, ic_hold;

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    alu_zero = 1'b0; imem_rdata = '0;
    #12;
    check("rst_state", state, 3'd0);
    check("rst_outputs", {imem_req, dmem_req, dmem_we, pc_inc, pc_load, reg_we, halted}, 7'd0);
    check("rst_ir", ir, 9'd0);
    check("rst_counts", {cycle_count, instr_count}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_start();
    run_instr(9'b00_0000_001, 1'b0, 0);   // R-type add
    check("instr_count_after_add", instr_count, 16'd1);
    run_instr(9'b01_0101_011, 1'b0, 0);   // I-type
    run_instr(9'b10_0000_000, 1'b1, 0);   // beq taken
    run_instr(9'b10_0000_000, 1'b0, 0);   // beq not taken
    run_instr(9'b10_1000_000, 1'b0, 0);   // unconditional branch
    run_instr(9'b11_1000_010, 1'b0, 0);   // jump
    run_instr(9'b11_0100_101, 1'b0, 1);   // store, ack after 1 wait
    run_instr(9'b11_0000_110, 1'b0, 3);   // load, ack after 3 waits
    run_instr(9'b11_0001_000, 1'b0, 0);   // load, immediate ack

    // Reset in the middle of a stalled fetch
    @(negedge clk) imem_ack = 1'b0;
    @(negedge clk);
    check("fetch_stall_req", imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_imem_req", imem_req, 1'b0);
    check("midreset_state", state, 3'd0);
    check("midreset_counts", {cycle_count, instr_count}, 32'd0);
    check("midreset_ir", ir, 9'd0);
    @(negedge clk) rst_n = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stale_ack_ignored", {state, pc_inc, cycle_count}, 20'd0);
    imem_ack = 1'b0; dmem_ack = 1'b0;

    // Saturation: the 4-bit counters stick at all-ones
    do_start();
    for (int i = 0; i < 20; i++) run_instr(9'(i % 8), 1'b0, 0);
    check("sat_instr_count", s_instr_count, 4'hF);
    check("sat_cycle_count", s_cycle_count, 4'hF);
    check("wide_instr_count", instr_count, 16'd20);
    check("wide_cycle_count", cycle_count, 16'd80);

    // Halt is sticky and ignores start
    run_instr(9'b11_1100_000, 1'b0, 0);
    check("halted", {halted, s_halted}, 2'b11);
    check("halt_state", state, 3'd6);
    cc_hold = int'(cycle_count);
    ic_hold = int'(instr_count);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    check("halt_after_start", {state, halted}, {3'd6, 1'b1});
    check("halt_cycle_frozen", cycle_count, cc_hold);
    check("halt_instr_frozen", instr_count, ic_hold);
    check("halt_outputs", {imem_req, dmem_req, pc_inc, pc_load, reg_we}, 5'd0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
